// File: rtl/if_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : if_pkg                                                       |
// | Brief  : Shared types for the IF-stage PC sequencing controller.      |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package if_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Encoded so that a numerically larger value has higher redirect priority.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_EXC  = 2'd3
    } redir_src_t;

    localparam logic [31:0] c_PC_INCR = 32'd4;

    function automatic redir_src_t redir_src(input logic exc, input logic br, input logic jmp);
        redir_src_t src;
        if (exc) begin
            src = SRC_EXC;
        end else if (br) begin
            src = SRC_BR;
        end else if (jmp) begin
            src = SRC_JMP;
        end else begin
            src = SRC_NONE;
        end
        return src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_pc_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : if_pc_ctrl_if                                                |
// | Brief  : PC register and instruction-memory handshake bundle.         |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
interface if_pc_ctrl_if;
    logic [31:0] PC_IF;
    logic [31:0] Next_PC_IF;
    logic        pc_stall;
    logic        Imem_req;
    logic        Imem_ack;
    logic        Imem_timeout;

    modport master (
        input  PC_IF,
        input  Imem_ack,
        output Next_PC_IF,
        output pc_stall,
        output Imem_req,
        output Imem_timeout
    );

    modport slave (
        output PC_IF,
        output Imem_ack,
        input  Next_PC_IF,
        input  pc_stall,
        input  Imem_req,
        input  Imem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/if_redirect_pend.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : if_redirect_pend                                             |
// | Brief  : Holds a redirect seen while the PC is frozen; a newer one    |
// |          replaces it only at equal or higher priority.                |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module if_redirect_pend
    import if_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_set,
    input  wire logic        i_clr,
    input  wire redir_src_t  i_src,
    input  wire logic [31:0] i_tgt,
    output logic             o_valid,
    output logic [31:0]      o_pc
);

    logic        r_valid;
    redir_src_t  r_src;
    logic [31:0] r_pc;
    logic        w_take;

    assign w_take = i_set && (!r_valid || (i_src >= r_src));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_src   <= SRC_NONE;
            r_pc    <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_src   <= SRC_NONE;
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_src   <= i_src;
            r_pc    <= i_tgt;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/if_pc_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : if_pc_ctrl                                                   |
// | Brief  : Chooses the next IF-stage PC and drives the pipeline         |
// |          stall/flush strobes. Option macro: IF_PC_CTRL_DELAY_SLOT_EN  |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module if_pc_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned MAX_WAIT     = 8
)(
    input  wire logic        Clk,
    input  wire logic        Rst_n,
    if_pc_ctrl_if.master     pc_bus,
    input  wire logic        Load_use_hazard,
    input  wire logic        Jump_ID,
    input  wire logic [31:0] Jump_target_ID,
    input  wire logic        Branch_taken_EX,
    input  wire logic [31:0] Branch_target_EX,
    input  wire logic        Exc_req,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush
);

    localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;

    redir_src_t  w_src;
    logic        w_redir;
    logic [31:0] w_tgt;
    logic        w_if_flush_redir;
    logic        w_id_flush_redir;

    logic        w_pend_valid;
    logic [31:0] w_pend_pc;
    logic        w_pend_set;
    logic        w_pend_clr;
    logic        w_consume;

    always_comb begin
        w_src   = redir_src(Exc_req, Branch_taken_EX, Jump_ID);
        w_redir = (w_src != SRC_NONE);
        case (w_src)
            SRC_EXC: w_tgt = EXC_VECTOR;
            SRC_BR:  w_tgt = Branch_target_EX;
            default: w_tgt = Jump_target_ID;
        endcase
    end

`ifdef IF_PC_CTRL_DELAY_SLOT_EN
    // The instruction behind a jump/branch is architecturally executed.
    assign w_if_flush_redir = Exc_req | Branch_taken_EX;
    assign w_id_flush_redir = Exc_req;
`else
    assign w_if_flush_redir = w_redir;
    assign w_id_flush_redir = Exc_req | Branch_taken_EX;
`endif

    // A redirect that arrives while the fetch decision is deferred is parked.
    assign w_pend_set = w_redir && !w_consume;

    if_redirect_pend u_pend (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .i_set   (w_pend_set),
        .i_clr   (w_pend_clr),
        .i_src   (w_src),
        .i_tgt   (w_tgt),
        .o_valid (w_pend_valid),
        .o_pc    (w_pend_pc)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state    <= ST_BOOT;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_wait_cnt_nxt      = r_wait_cnt;
        w_pend_clr          = 1'b0;
        w_consume           = 1'b0;
        pc_bus.Imem_req     = 1'b0;
        pc_bus.Next_PC_IF   = pc_bus.PC_IF;
        pc_bus.pc_stall     = 1'b1;
        pc_bus.Imem_timeout = 1'b0;
        IF_ID_stall         = 1'b0;
        IF_ID_flush         = w_if_flush_redir;
        ID_EX_flush         = w_id_flush_redir;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                pc_bus.Imem_req = 1'b1;
                if (pc_bus.Imem_ack) begin
                    w_consume      = 1'b1;
                    w_state_nxt    = ST_FETCH;
                    w_wait_cnt_nxt = '0;
                    if (w_redir) begin
                        pc_bus.Next_PC_IF = w_tgt;
                        pc_bus.pc_stall   = 1'b0;
                        w_pend_clr        = 1'b1;
                    end else if (w_pend_valid) begin
                        pc_bus.Next_PC_IF = w_pend_pc;
                        pc_bus.pc_stall   = 1'b0;
                        w_pend_clr        = 1'b1;
                    end else if (Load_use_hazard) begin
                        IF_ID_stall = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else begin
                        pc_bus.Next_PC_IF = pc_bus.PC_IF + c_PC_INCR;
                        pc_bus.pc_stall   = 1'b0;
                    end
                end else if ((r_state == ST_WAIT) && (r_wait_cnt == c_WAIT_LAST)) begin
                    // Memory never answered: abandon the fetch and trap.
                    pc_bus.Imem_timeout = 1'b1;
                    pc_bus.Next_PC_IF   = EXC_VECTOR;
                    pc_bus.pc_stall     = 1'b0;
                    IF_ID_flush         = 1'b1;
                    ID_EX_flush         = 1'b1;
                    w_pend_clr          = 1'b1;
                    w_state_nxt         = ST_FETCH;
                    w_wait_cnt_nxt      = '0;
                end else if (r_state == ST_FETCH) begin
                    w_state_nxt    = ST_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        if (!Rst_n) begin
            pc_bus.Imem_req     = 1'b0;
            pc_bus.Next_PC_IF   = RESET_VECTOR;
            pc_bus.pc_stall     = 1'b0;
            pc_bus.Imem_timeout = 1'b0;
            IF_ID_stall         = 1'b0;
            IF_ID_flush         = 1'b0;
            ID_EX_flush         = 1'b0;
            w_pend_clr          = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/if_pc_ctrl.md
Name: if_pc_ctrl

Overview:
Sequencing controller for the IF-stage PC register. Each cycle it chooses the next PC (reset vector, exception vector, EX branch target, ID jump target, or PC+4) and drives pc_stall and the pipeline flush/stall strobes. It handshakes with instruction memory and holds the PC while a fetch is outstanding. It sits between the hazard/branch logic and the PC register in the IF stage.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded out of reset
EXC_VECTOR, 32'h0000_0080, PC loaded on exception or imem timeout
MAX_WAIT, 8, imem wait cycles before timeout (2..255)

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  synchronous active-low reset
PC_IF  in  32  current PC from PC register
Imem_req  out  1  fetch request for PC_IF
Imem_ack  in  1  fetch complete this cycle
Load_use_hazard  in  1  ID load-use hazard
Jump_ID  in  1  jump resolved in ID
Jump_target_ID  in  32  jump target
Branch_taken_EX  in  1  taken branch resolved in EX
Branch_target_EX  in  32  branch target
Exc_req  in  1  exception request (single-cycle pulse)
Next_PC_IF  out  32  next PC to PC register
pc_stall  out  1  hold PC register
IF_ID_stall  out  1  hold IF/ID register
IF_ID_flush  out  1  bubble IF/ID
ID_EX_flush  out  1  bubble ID/EX
Imem_timeout  out  1  one-cycle timeout pulse

Behaviour:
- One clock (Clk). Reset is synchronous and active-low (Rst_n).
- Reset: while Rst_n=0, Next_PC_IF=RESET_VECTOR and pc_stall=0, so the PC register loads the vector. All other outputs are 0, state=BOOT, wait_cnt=0, pend_valid=0.
- Redirect target (tgt), by priority: Exc_req -> EXC_VECTOR; else Branch_taken_EX -> Branch_target_EX; else Jump_ID -> Jump_target_ID.
- Outputs are combinational from state and inputs, so there is zero-cycle latency. State registers update on Clk.
- BOOT:
  - Imem_req=0, pc_stall=1.
  - Go to FETCH after 1 cycle.
- FETCH:
  - Imem_req=1.
  - If Imem_ack=1 and a redirect is present: Next_PC_IF=tgt, pc_stall=0.
  - Else if Imem_ack=1 and pend_valid=1: Next_PC_IF=pend_pc, pc_stall=0, clear pend_valid.
  - Else if Imem_ack=1 and Load_use_hazard=1: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1.
  - Else if Imem_ack=1: Next_PC_IF=PC_IF+4 (mod 2^32, wraps FFFF_FFFC->0), pc_stall=0.
  - If Imem_ack=0: pc_stall=1, go to WAIT, wait_cnt<=1.
- WAIT:
  - Imem_req=1, pc_stall=1.
  - On Imem_ack: same decision as FETCH, go to FETCH, wait_cnt<=0.
  - If wait_cnt==MAX_WAIT-1 and no ack: Imem_timeout=1, Next_PC_IF=EXC_VECTOR, pc_stall=0, both flushes=1, clear pend_valid, go to FETCH.
- Redirect while the PC is held (no ack): latch pend_pc<=tgt and pend_valid<=1. A later redirect overwrites only if its priority is ≥ the latched one. An exception always overwrites.
- A redirect (immediate or latched) overrides Load_use_hazard. IF_ID_stall is 0 whenever a redirect is active.
- Flushes are asserted in the cycle the redirect input is seen, whether or not ack is present:
  - Exc_req -> IF_ID_flush=1, ID_EX_flush=1.
  - Branch_taken_EX -> IF_ID_flush=1, ID_EX_flush=1.
  - Jump_ID -> IF_ID_flush=1.
- Exc_req together with Branch_taken_EX: the exception wins and the target is EXC_VECTOR.
- Rst_n low mid-WAIT: the fetch is abandoned, the pending redirect is discarded, and the block re-enters BOOT.

Optional Feature:
IF_PC_CTRL_DELAY_SLOT_EN:
- Defined: MIPS delay slot.
  - Jump_ID causes no flush.
  - Branch_taken_EX asserts IF_ID_flush only; the delay slot in ID survives.
  - Exceptions still flush both.
- Undefined: flushes exactly as listed in Behaviour.

Decomposition:
- Shared package if_pkg: FSM state encoding (BOOT, FETCH, WAIT), redirect-source encoding (NONE, JMP, BR, EXC), and the PC increment constant 4.
- One sub-module, if_redirect_pend: the pend_pc/pend_valid register with priority-overwrite logic.

Test Plan:
1. Rst_n=0 for 3 cycles, then 1, with Imem_ack=1 -> Next_PC_IF=0000_0000 during reset; Imem_req rises 1 cycle after release; then PC steps 0,4,8.
2. PC=0000_0010, Load_use_hazard=1 for 1 cycle -> pc_stall=1, IF_ID_stall=1, ID_EX_flush=1; the next cycle gives Next_PC_IF=0000_0014.
3. PC=0000_0020, Branch_taken_EX=1, target=0000_0100, with Jump_ID=1 in the same cycle -> Next_PC_IF=0000_0100, both flushes=1 (only IF_ID_flush with DELAY_SLOT_EN).
4. Imem_ack=0 for 3 cycles with Jump_ID pulse (target=0000_0200) in cycle 2 -> pc_stall=1 throughout, IF_ID_flush in cycle 2; on ack, Next_PC_IF=0000_0200.
5. Imem_ack held 0, MAX_WAIT=8 -> Imem_timeout pulse in the 8th stall cycle, Next_PC_IF=0000_0080.
6. PC=FFFF_FFFC, ack=1 -> Next_PC_IF=0000_0000; Exc_req in the same cycle as Branch_taken_EX -> 0000_0080.
